// File: rtl/spi_rpi_frame_slave.sv
// SPI mode-0 slave frame transceiver: shifts DATA_TX out on MISO and commits the received frame to DATA_RX.
// Optional macro SPI_RPI_SEQ_HEADER_EN replaces tx byte 0 with the bit-reversed FRAME_CNT[7:0].
module spi_rpi_frame_slave #(
  parameter int FRAME_BYTES = 88,
  parameter int DATA_W      = 1024
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SPI_SCLK,
  input  logic              SPI_CS_N,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic              SPI_MISO_OE,
  input  logic [DATA_W-1:0] DATA_TX,
  output logic [DATA_W-1:0] DATA_RX,
  output logic              FRAME_OK,
  output logic              FRAME_ERR,
  output logic [15:0]       FRAME_CNT,
  output logic              BUSY
);

  localparam int NBITS = FRAME_BYTES * 8;
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam int IDX_W = $clog2(NBITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, FRAME_END} state_t;

  state_t           state;
  logic [2:0]       sclk_s, cs_s, mosi_s;
  logic [NBITS-1:0] tx, rx, tx_load;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;
  logic             sclk_rise, sclk_fall, cs_rise, cs_fall, cs_sync, mosi_sync;
  logic             unused_bits;

  // [1:0] is the 2-FF synchronizer, [2] the history FF used for edge detect.
  // CS sync resets low so a frame already in progress at reset is never picked up.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sclk_s <= '0;
      cs_s   <= '0;
      mosi_s <= '0;
    end else begin
      sclk_s <= {sclk_s[1:0], SPI_SCLK};
      cs_s   <= {cs_s[1:0], SPI_CS_N};
      mosi_s <= {mosi_s[1:0], SPI_MOSI};
    end
  end

  assign sclk_rise   = sclk_s[1] & ~sclk_s[2];
  assign sclk_fall   = ~sclk_s[1] & sclk_s[2];
  assign cs_rise     = cs_s[1] & ~cs_s[2];
  assign cs_fall     = ~cs_s[1] & cs_s[2];
  assign cs_sync     = cs_s[1];
  assign mosi_sync   = mosi_s[1];
  assign unused_bits = ^{DATA_TX, mosi_s[2]};

  always_comb begin
    tx_load = DATA_TX[NBITS-1:0];
`ifdef SPI_RPI_SEQ_HEADER_EN
    for (int i = 0; i < 8; i++) tx_load[7-i] = FRAME_CNT[i];
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= WAIT_IDLE;
      tx          <= '0;
      rx          <= '0;
      bit_cnt     <= '0;
      overrun     <= 1'b0;
      SPI_MISO    <= 1'b0;
      SPI_MISO_OE <= 1'b0;
      DATA_RX     <= '0;
      FRAME_OK    <= 1'b0;
      FRAME_ERR   <= 1'b0;
      FRAME_CNT   <= '0;
      BUSY        <= 1'b0;
    end else begin
      FRAME_OK  <= 1'b0;
      FRAME_ERR <= 1'b0;
      case (state)
        WAIT_IDLE: if (cs_sync) state <= IDLE;
        IDLE: begin
          if (cs_fall) begin
            tx          <= tx_load;
            rx          <= '0;
            bit_cnt     <= '0;
            overrun     <= 1'b0;
            SPI_MISO    <= tx_load[0];
            SPI_MISO_OE <= 1'b1;
            BUSY        <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          // CS rising takes priority over any SCLK edge seen in the same cycle.
          if (cs_rise) begin
            state <= FRAME_END;
          end else if (sclk_rise) begin
            if (bit_cnt == LAST) begin
              overrun  <= 1'b1;
              SPI_MISO <= 1'b0;
            end else begin
              rx[IDX_W'(bit_cnt)] <= mosi_sync;
              bit_cnt             <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall) begin
            SPI_MISO <= (bit_cnt == LAST) ? 1'b0 : tx[IDX_W'(bit_cnt)];
          end
        end
        FRAME_END: begin
          if (bit_cnt == LAST && !overrun) begin
            DATA_RX   <= DATA_W'(rx);
            FRAME_OK  <= 1'b1;
            FRAME_CNT <= FRAME_CNT + 16'd1;
          end else begin
            FRAME_ERR <= 1'b1;
          end
          SPI_MISO    <= 1'b0;
          SPI_MISO_OE <= 1'b0;
          BUSY        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rpi_frame_slave.sv
// Randomized bench for spi_rpi_frame_slave: drives SPI mode-0 frames and checks against a frame-level model.
module tb_spi_rpi_frame_slave;

  localparam int DW = 1024;
  localparam int NB = 704;

  logic          CLK = 1'b0;
  logic          RESET, SPI_SCLK, SPI_CS_N, SPI_MOSI;
  logic          SPI_MISO, SPI_MISO_OE, FRAME_OK, FRAME_ERR, BUSY;
  logic [DW-1:0] DATA_TX, DATA_RX;
  logic [15:0]   FRAME_CNT;

  spi_rpi_frame_slave #(.FRAME_BYTES(88), .DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET), .SPI_SCLK(SPI_SCLK), .SPI_CS_N(SPI_CS_N),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE),
    .DATA_TX(DATA_TX), .DATA_RX(DATA_RX), .FRAME_OK(FRAME_OK),
    .FRAME_ERR(FRAME_ERR), .FRAME_CNT(FRAME_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int            checks = 0, errors = 0;
  int            ok_cnt = 0, err_cnt = 0;
  logic [DW-1:0] mosi_v, miso_v, exp_rx;
  logic [15:0]   exp_cnt;
  logic          busy_mid, oe_mid;

  always @(negedge CLK) begin
    if (FRAME_OK)  ok_cnt++;
    if (FRAME_ERR) err_cnt++;
  end

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // What the master should see on MISO: the snapshot's first NB bits, zero past the frame.
  function automatic logic [DW-1:0] exp_tx(input logic [DW-1:0] d, input logic [15:0] cnt);
    logic [DW-1:0] t;
    t = '0;
    for (int n = 0; n < NB; n++) t[n] = d[n];
`ifdef SPI_RPI_SEQ_HEADER_EN
    for (int n = 0; n < 8; n++) t[n] = cnt[7-n];
`endif
    return t;
  endfunction

  function automatic logic [DW-1:0] first_bits(input logic [DW-1:0] d);
    logic [DW-1:0] t;
    t = '0;
    for (int n = 0; n < NB; n++) t[n] = d[n];
    return t;
  endfunction

  function automatic int miso_bad(input int nbits, input logic [DW-1:0] e);
    int bad = 0;
    for (int n = 0; n < nbits; n++) if (miso_v[n] !== e[n]) bad++;
    return bad;
  endfunction

  // SCLK period is 8 CLK; all pin changes land on CLK falling edges.
  task automatic run_frame(input int nbits, input int rst_at, input int chg_at,
                           input logic [DW-1:0] chg_val);
    @(negedge CLK);
    SPI_CS_N = 1'b0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin RESET = 1'b1; #20; RESET = 1'b0; end
      if (i == chg_at) DATA_TX = chg_val;
      SPI_MOSI = mosi_v[i];
      #40;
      SPI_SCLK  = 1'b1;
      miso_v[i] = SPI_MISO;
      if (i == nbits / 2) begin busy_mid = BUSY; oe_mid = SPI_MISO_OE; end
      #40;
      SPI_SCLK = 1'b0;
    end
    #40;
    SPI_CS_N = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    RESET = 1'b1; SPI_SCLK = 1'b0; SPI_CS_N = 1'b1; SPI_MOSI = 1'b0; DATA_TX = '0;
    repeat (2) @(negedge CLK);
    checks++; if (SPI_MISO !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", SPI_MISO); end
    checks++; if (SPI_MISO_OE !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", SPI_MISO_OE); end
    checks++; if (DATA_RX !== '0) begin errors++; $display("FAIL reset_data_rx: got %h want 0", DATA_RX); end
    checks++; if (FRAME_OK !== 1'b0 || FRAME_ERR !== 1'b0) begin errors++; $display("FAIL reset_pulses: ok %b err %b want 0 0", FRAME_OK, FRAME_ERR); end
    checks++; if (FRAME_CNT !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", FRAME_CNT); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    RESET = 1'b0;
    exp_rx = '0; exp_cnt = '0;
    #100;
  endtask

  task automatic test_full_frame();
    int ok0, err0;
    logic [DW-1:0] e;
    DATA_TX = rand_vec();
    DATA_TX[15:8] = 8'hA5;
    for (int n = 0; n < DW; n++) mosi_v[n] = n[0];
    e = exp_tx(DATA_TX, exp_cnt);
    ok0 = ok_cnt; err0 = err_cnt;
    run_frame(NB, -1, -1, '0);
    exp_rx = first_bits(mosi_v); exp_cnt++;
    checks++; if (miso_bad(NB, e) != 0) begin errors++; $display("FAIL full_miso: %0d wrong bits want 0", miso_bad(NB, e)); end
    checks++; if (miso_v[15:8] !== 8'hA5) begin errors++; $display("FAIL full_byte1: got %h want a5", miso_v[15:8]); end
    checks++; if (ok_cnt - ok0 != 1 || err_cnt - err0 != 0) begin errors++; $display("FAIL full_pulses: ok %0d err %0d want 1 0", ok_cnt - ok0, err_cnt - err0); end
    checks++; if (DATA_RX !== exp_rx) begin errors++; $display("FAIL full_data_rx: got %h want %h", DATA_RX, exp_rx); end
    checks++; if (FRAME_CNT !== exp_cnt) begin errors++; $display("FAIL full_cnt: got %0d want %0d", FRAME_CNT, exp_cnt); end
    checks++; if (busy_mid !== 1'b1 || oe_mid !== 1'b1) begin errors++; $display("FAIL full_mid_busy_oe: got %b %b want 1 1", busy_mid, oe_mid); end
    checks++; if (BUSY !== 1'b0 || SPI_MISO_OE !== 1'b0) begin errors++; $display("FAIL full_end_busy_oe: got %b %b want 0 0", BUSY, SPI_MISO_OE); end
  endtask

  task automatic test_bad_length();
    int ok0, err0;
    int lens[3] = '{NB - 1, NB + 1, 0};
    logic [DW-1:0] e;
    for (int k = 0; k < 3; k++) begin
      DATA_TX = rand_vec();
      mosi_v  = rand_vec();
      e = exp_tx(DATA_TX, exp_cnt);
      ok0 = ok_cnt; err0 = err_cnt;
      run_frame(lens[k], -1, -1, '0);
      checks++; if (ok_cnt - ok0 != 0 || err_cnt - err0 != 1) begin errors++; $display("FAIL bad_len%0d_pulses: ok %0d err %0d want 0 1", lens[k], ok_cnt - ok0, err_cnt - err0); end
      checks++; if (DATA_RX !== exp_rx) begin errors++; $display("FAIL bad_len%0d_data_rx: got %h want %h", lens[k], DATA_RX, exp_rx); end
      checks++; if (FRAME_CNT !== exp_cnt) begin errors++; $display("FAIL bad_len%0d_cnt: got %0d want %0d", lens[k], FRAME_CNT, exp_cnt); end
      checks++; if (miso_bad(lens[k], e) != 0) begin errors++; $display("FAIL bad_len%0d_miso: %0d wrong bits want 0", lens[k], miso_bad(lens[k], e)); end
    end
  endtask

  task automatic test_snapshot();
    logic [DW-1:0] e;
    DATA_TX = '0;
    mosi_v  = rand_vec();
    e = exp_tx('0, exp_cnt);
    run_frame(NB, -1, 300, '1);
    exp_rx = first_bits(mosi_v); exp_cnt++;
    checks++; if (miso_bad(NB, e) != 0) begin errors++; $display("FAIL snap_held_miso: %0d wrong bits want 0", miso_bad(NB, e)); end
    checks++; if (DATA_RX !== exp_rx) begin errors++; $display("FAIL snap_data_rx: got %h want %h", DATA_RX, exp_rx); end
    mosi_v = rand_vec();
    e = exp_tx(DATA_TX, exp_cnt);
    run_frame(NB, -1, -1, '0);
    exp_rx = first_bits(mosi_v); exp_cnt++;
    checks++; if (miso_bad(NB, e) != 0) begin errors++; $display("FAIL snap_next_miso: %0d wrong bits want 0", miso_bad(NB, e)); end
    checks++; if (FRAME_CNT !== exp_cnt) begin errors++; $display("FAIL snap_cnt: got %0d want %0d", FRAME_CNT, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    int ok0, err0;
    logic [DW-1:0] e;
    DATA_TX = rand_vec();
    mosi_v  = rand_vec();
    ok0 = ok_cnt; err0 = err_cnt;
    run_frame(NB, 300, -1, '0);
    exp_rx = '0; exp_cnt = '0;
    checks++; if (ok_cnt - ok0 != 0 || err_cnt - err0 != 0) begin errors++; $display("FAIL rstmid_pulses: ok %0d err %0d want 0 0", ok_cnt - ok0, err_cnt - err0); end
    checks++; if (DATA_RX !== exp_rx || FRAME_CNT !== exp_cnt) begin errors++; $display("FAIL rstmid_state: rx %h cnt %0d want 0 0", DATA_RX, FRAME_CNT); end
    checks++; if (miso_v[NB-1:300] !== '0 || busy_mid !== 1'b0) begin errors++; $display("FAIL rstmid_ignored: miso %h busy %b want 0 0", miso_v[NB-1:300], busy_mid); end
    DATA_TX = rand_vec();
    mosi_v  = rand_vec();
    e = exp_tx(DATA_TX, exp_cnt);
    ok0 = ok_cnt;
    run_frame(NB, -1, -1, '0);
    exp_rx = first_bits(mosi_v); exp_cnt++;
    checks++; if (ok_cnt - ok0 != 1 || DATA_RX !== exp_rx) begin errors++; $display("FAIL rstmid_recover: ok %0d rx %h want 1 %h", ok_cnt - ok0, DATA_RX, exp_rx); end
    checks++; if (miso_bad(NB, e) != 0) begin errors++; $display("FAIL rstmid_recover_miso: %0d wrong bits want 0", miso_bad(NB, e)); end
  endtask

  task automatic test_back_to_back();
    int ok0;
    logic [DW-1:0] e;
    for (int k = 0; k < 3; k++) begin
      DATA_TX = rand_vec();
      mosi_v  = rand_vec();
      e = exp_tx(DATA_TX, exp_cnt);
      ok0 = ok_cnt;
      run_frame(NB, -1, -1, '0);
`ifdef SPI_RPI_SEQ_HEADER_EN
      if (exp_cnt == 16'd3) begin
        checks++; if (miso_v[7:0] !== 8'b1100_0000) begin errors++; $display("FAIL seq_header3: got %b want 11000000", miso_v[7:0]); end
      end
`endif
      exp_rx = first_bits(mosi_v); exp_cnt++;
      checks++; if (miso_bad(NB, e) != 0) begin errors++; $display("FAIL b2b%0d_miso: %0d wrong bits want 0", k, miso_bad(NB, e)); end
      checks++; if (ok_cnt - ok0 != 1 || DATA_RX !== exp_rx) begin errors++; $display("FAIL b2b%0d_commit: ok %0d rx %h want 1 %h", k, ok_cnt - ok0, DATA_RX, exp_rx); end
      checks++; if (FRAME_CNT !== exp_cnt) begin errors++; $display("FAIL b2b%0d_cnt: got %0d want %0d", k, FRAME_CNT, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_bad_length();
    test_snapshot();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
